sha256_transform_pipe: RTL

- Parametrised SHA-256 compression pipeline with an internal loop counter and valid/ready input handshake.
- Per-block initial state (midstate) and a user tag travel with each block; output is a valid-qualified hash plus tag.
- Drop-in successor for the miner hashing core: the controller no longer drives cnt/feedback and may change midstate every block.
- 64/LOOP round stages; each stage iterates LOOP rounds.

---
 rtl/sha256_pkg.sv | 81 ++++++++
 rtl/sha256_round_stage.sv | 55 +++++
 rtl/sha256_transform_pipe.sv | 116 +++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round helpers and the per-stage datapath bundle
// for the looped compression pipeline.
package sha256_pkg;

  localparam logic [255:0] H0 = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  // Ascending index range so K[0] is the first constant listed.
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef logic [15:0][31:0] sched_t;
  typedef logic [7:0][31:0]  words8_t;

  typedef struct packed {
    sched_t  w;
    words8_t st;
    words8_t init;
  } stage_t;

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // One round on a rolling 16-word schedule window: W0 is consumed, the
  // window shifts down a word and the freshly expanded word enters at W15.
  function automatic stage_t round_step(input stage_t s, input logic [31:0] k);
    stage_t      r;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] w_new;
    t1    = s.st[7] + big_sigma1(s.st[4]) + ch(s.st[4], s.st[5], s.st[6]) + k + s.w[0];
    t2    = big_sigma0(s.st[0]) + maj(s.st[0], s.st[1], s.st[2]);
    w_new = small_sigma1(s.w[14]) + s.w[9] + small_sigma0(s.w[1]) + s.w[0];
    r.w    = {w_new, s.w[15:1]};
    r.st   = {s.st[6:4], s.st[3] + t1, s.st[2:0], t1 + t2};
    r.init = s.init;
    return r;
  endfunction

endpackage

// File: rtl/sha256_round_stage.sv
// One pipeline stage: either loads the upstream bundle or iterates on its own
// registers, applying one SHA-256 round per clock.
module sha256_round_stage
  import sha256_pkg::*;
#(
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [31:0]      k,
  input  logic             prev_v,
  input  stage_t           prev_dat,
  input  logic [TAG_W-1:0] prev_tag,
  output logic             v,
  output stage_t           dat,
  output logic [TAG_W-1:0] tag
);

  logic             v_q,   v_d;
  stage_t           dat_q, dat_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  stage_t           src;

  always_comb begin
    src   = dat_q;
    v_d   = v_q;
    tag_d = tag_q;
    if (load) begin
      src   = prev_dat;
      v_d   = prev_v;
      tag_d = prev_tag;
    end
    dat_d = round_step(src, k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
    end else begin
      v_q <= v_d;
    end
  end

  // Datapath is left unreset; only the valid bit gates what it means.
  always_ff @(posedge clk) begin
    dat_q <= dat_d;
    tag_q <= tag_d;
  end

  assign v   = v_q;
  assign dat = dat_q;
  assign tag = tag_q;

endmodule

// File: rtl/sha256_transform_pipe.sv
// Looped SHA-256 compression pipeline: 64/LOOP stages of LOOP rounds each,
// shared round counter, valid/ready input and a registered final-add output.
module sha256_transform_pipe
  import sha256_pkg::*;
#(
  parameter int LOOP  = 4,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [255:0]     in_state,
  input  logic [511:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [255:0]     out_hash,
  output logic [TAG_W-1:0] out_tag
);

  if (LOOP != 1 && LOOP != 2 && LOOP != 4 && LOOP != 8 &&
      LOOP != 16 && LOOP != 32 && LOOP != 64) begin : g_bad_loop
    $error("sha256_transform_pipe: LOOP must be a power of two from 1 to 64");
  end

  localparam int         NSTAGE  = 64 / LOOP;
  localparam logic [5:0] CNT_MAX = 6'(LOOP - 1);

  logic [5:0]       cnt_q, cnt_d;
  logic             load;
  logic             out_valid_q, out_valid_d;
  words8_t          out_hash_q,  out_hash_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;

  // Chain index 0 is the input port bundle; index s+1 is stage s.
  logic             v_c   [NSTAGE+1];
  stage_t           dat_c [NSTAGE+1];
  logic [TAG_W-1:0] tag_c [NSTAGE+1];

  assign load     = (cnt_q == 6'd0);
  assign in_ready = load && !rst;

  always_comb begin
    cnt_d = cnt_q + 6'd1;
    if (cnt_q == CNT_MAX) begin
      cnt_d = 6'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign v_c[0]   = in_valid && in_ready;
  assign dat_c[0] = '{w: in_data, st: in_state, init: in_state};
  assign tag_c[0] = in_tag;

  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    logic [5:0]  k_idx;
    logic [31:0] k_s;

    assign k_idx = 6'(LOOP * s) + cnt_q;
    assign k_s   = K[k_idx];

    sha256_round_stage #(
      .TAG_W (TAG_W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .k        (k_s),
      .prev_v   (v_c[s]),
      .prev_dat (dat_c[s]),
      .prev_tag (tag_c[s]),
      .v        (v_c[s+1]),
      .dat      (dat_c[s+1]),
      .tag      (tag_c[s+1])
    );
  end

  // The retiring block is finalised with its own carried init state, so a
  // midstate change on the same edge cannot corrupt it.
  always_comb begin
    out_valid_d = 1'b0;
    out_hash_d  = out_hash_q;
    out_tag_d   = out_tag_q;
    if (load && v_c[NSTAGE]) begin
      out_valid_d = 1'b1;
      for (int i = 0; i < 8; i++) begin
        out_hash_d[i] = dat_c[NSTAGE].init[i] + dat_c[NSTAGE].st[i];
      end
      out_tag_d = tag_c[NSTAGE];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_hash_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_hash_q  <= out_hash_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_hash  = out_hash_q;
  assign out_tag   = out_tag_q;

endmodule
